reg_cmd_sequencer: RTL and testbench

Upstream control stage for the n-bit register. It accepts register commands (clear/load/decrement/increment plus a repeat count) over a valid/ready handshake and drives the register's E, FunSel and I inputs, one operation per enabled clock cycle. It keeps a shadow copy of the value the register will hold, and pulses done when a command completes. It sits between the control unit and one n-bit register instance.

---
 rtl/reg_cmd_sequencer_pkg.sv | 34 +++
 rtl/reg_cmd_sequencer_if.sv | 29 ++
 rtl/reg_cmd_sequencer.sv | 73 +++++++
 tb/tb_reg_cmd_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_cmd_sequencer_pkg.sv
// Shared encodings and the shadow-update rule for the register command sequencer.
// The shadow rule lives here so every user predicts register content the same way.
package reg_cmd_sequencer_pkg;

    localparam int SEQ_N  = 8;
    localparam int SEQ_CW = 4;

    localparam logic [1:0] FS_CLR  = 2'b00;
    localparam logic [1:0] FS_LOAD = 2'b01;
    localparam logic [1:0] FS_DEC  = 2'b10;
    localparam logic [1:0] FS_INC  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Register content after one enabled clock with the given FunSel; inc/dec wrap.
    function automatic logic [SEQ_N-1:0] next_shadow(
        input logic [1:0]       op,
        input logic [SEQ_N-1:0] shadow,
        input logic [SEQ_N-1:0] data
    );
        logic [SEQ_N-1:0] result;
        case (op)
            FS_CLR:  result = '0;
            FS_LOAD: result = data;
            FS_DEC:  result = shadow - 1'b1;
            default: result = shadow + 1'b1;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/reg_cmd_sequencer_if.sv
// Command handshake plus register drive bundle between control unit and sequencer.
// master = control unit side, slave = sequencer side.
interface reg_cmd_sequencer_if #(
    parameter int N  = 8,
    parameter int CW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [N-1:0]  cmd_data;
    logic [CW-1:0] cmd_count;
    logic          hold;
    logic          E;
    logic [1:0]    FunSel;
    logic [N-1:0]  I;
    logic [N-1:0]  Shadow;
    logic          busy;
    logic          done;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, hold,
        input  cmd_ready, E, FunSel, I, Shadow, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, hold,
        output cmd_ready, E, FunSel, I, Shadow, busy, done
    );
endinterface

// File: rtl/reg_cmd_sequencer.sv
// Issues one register operation per un-held cycle for each accepted command and
// tracks the value the register will hold.
//   state    | meaning
//   ST_IDLE  | waiting for a command, cmd_ready high, E low
//   ST_ISSUE | FunSel/I stable, E = !hold, counting down remaining operations
module reg_cmd_sequencer
    import reg_cmd_sequencer_pkg::*;
#(
    parameter int N  = SEQ_N,
    parameter int CW = SEQ_CW
) (
    input  logic                 Clock,
    input  logic                 Reset,
    reg_cmd_sequencer_if.slave   bus
);

    state_t        r_state;
    logic [CW-1:0] r_remaining;
    logic [1:0]    r_funsel;
    logic [N-1:0]  r_data;
    logic [N-1:0]  r_shadow;
    logic          r_done;

    logic          w_issue;
    logic [CW-1:0] w_count;

    assign w_issue = (r_state == ST_ISSUE) && !bus.hold && !Reset;
    // A zero repeat count still performs one inc/dec.
    assign w_count = (bus.cmd_count == '0) ? CW'(1) : bus.cmd_count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_funsel    <= FS_CLR;
            r_data      <= '0;
            r_shadow    <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_funsel    <= bus.cmd_op;
                        r_data      <= bus.cmd_data;
                        r_remaining <= bus.cmd_op[1] ? w_count : CW'(1);
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        r_shadow    <= next_shadow(r_funsel, r_shadow, r_data);
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == CW'(1)) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE) && !Reset;
    assign bus.E         = w_issue;
    assign bus.FunSel    = r_funsel;
    assign bus.I         = r_data;
    assign bus.Shadow    = r_shadow;
    assign bus.busy      = (r_state == ST_ISSUE);
    assign bus.done      = r_done;

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Directed vector table for the command sequencer, plus hand sequences for
// reset mid-command and back-to-back commands with a shadow scoreboard.
module tb_reg_cmd_sequencer;
    import reg_cmd_sequencer_pkg::*;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 Clock = ~Clock;

    reg_cmd_sequencer_if #(.N(8), .CW(4)) bus ();

    reg_cmd_sequencer #(.N(8), .CW(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic       valid;
        logic [1:0] op;
        logic [7:0] data;
        logic [3:0] cnt;
        logic       hold;
        logic       e;
        logic [1:0] fs;
        logic [7:0] i;
        logic [7:0] sh;
        logic       rdy;
        logic       busy;
        logic       done;
    } vec_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [3:0] cnt;
    } cmd_t;

    localparam int NV = 31;
    localparam int NC = 8;
    vec_t vt [NV];
    cmd_t cmds [NC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] d,
                         input logic [3:0] c, input logic h);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        bus.cmd_count = c;
        bus.hold      = h;
    endtask

    initial begin
        // rst valid op data cnt hold | E FunSel I Shadow ready busy done
        vt[0]  = '{1'b1,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b0,2'd0,8'h00,8'h00,1'b0,1'b0,1'b0};
        vt[1]  = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b0,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0};
        vt[2]  = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b0,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0};
        vt[3]  = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b0,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0};
        vt[4]  = '{1'b0,1'b1,2'd1,8'hA5,4'd0,1'b0, 1'b0,2'd0,8'h00,8'h00,1'b1,1'b0,1'b0};
        vt[5]  = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b1,2'd1,8'hA5,8'h00,1'b0,1'b1,1'b0};
        vt[6]  = '{1'b0,1'b1,2'd3,8'h00,4'd3,1'b0, 1'b0,2'd1,8'hA5,8'hA5,1'b1,1'b0,1'b1};
        vt[7]  = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b1,2'd3,8'h00,8'hA5,1'b0,1'b1,1'b0};
        vt[8]  = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b1,2'd3,8'h00,8'hA6,1'b0,1'b1,1'b0};
        vt[9]  = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b1,2'd3,8'h00,8'hA7,1'b0,1'b1,1'b0};
        vt[10] = '{1'b0,1'b1,2'd1,8'h01,4'd5,1'b0, 1'b0,2'd3,8'h00,8'hA8,1'b1,1'b0,1'b1};
        vt[11] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b1,2'd1,8'h01,8'hA8,1'b0,1'b1,1'b0};
        vt[12] = '{1'b0,1'b1,2'd2,8'h33,4'd0,1'b0, 1'b0,2'd1,8'h01,8'h01,1'b1,1'b0,1'b1};
        vt[13] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b1,2'd2,8'h33,8'h01,1'b0,1'b1,1'b0};
        vt[14] = '{1'b0,1'b1,2'd2,8'h00,4'd2,1'b0, 1'b0,2'd2,8'h33,8'h00,1'b1,1'b0,1'b1};
        vt[15] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b1,2'd2,8'h00,8'h00,1'b0,1'b1,1'b0};
        vt[16] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b1,2'd2,8'h00,8'hFF,1'b0,1'b1,1'b0};
        vt[17] = '{1'b0,1'b1,2'd3,8'h00,4'd4,1'b0, 1'b0,2'd2,8'h00,8'hFE,1'b1,1'b0,1'b1};
        vt[18] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b1,2'd3,8'h00,8'hFE,1'b0,1'b1,1'b0};
        vt[19] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b1, 1'b0,2'd3,8'h00,8'hFF,1'b0,1'b1,1'b0};
        vt[20] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b1, 1'b0,2'd3,8'h00,8'hFF,1'b0,1'b1,1'b0};
        vt[21] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b1,2'd3,8'h00,8'hFF,1'b0,1'b1,1'b0};
        vt[22] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b1,2'd3,8'h00,8'h00,1'b0,1'b1,1'b0};
        vt[23] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b1,2'd3,8'h00,8'h01,1'b0,1'b1,1'b0};
        vt[24] = '{1'b0,1'b1,2'd3,8'h00,4'd1,1'b0, 1'b0,2'd3,8'h00,8'h02,1'b1,1'b0,1'b1};
        vt[25] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b1, 1'b0,2'd3,8'h00,8'h02,1'b0,1'b1,1'b0};
        vt[26] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b1,2'd3,8'h00,8'h02,1'b0,1'b1,1'b0};
        vt[27] = '{1'b0,1'b1,2'd0,8'h77,4'd9,1'b0, 1'b0,2'd3,8'h00,8'h03,1'b1,1'b0,1'b1};
        vt[28] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b1,2'd0,8'h77,8'h03,1'b0,1'b1,1'b0};
        vt[29] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b0, 1'b0,2'd0,8'h77,8'h00,1'b1,1'b0,1'b1};
        vt[30] = '{1'b0,1'b0,2'd0,8'h00,4'd0,1'b1, 1'b0,2'd0,8'h77,8'h00,1'b1,1'b0,1'b0};

        cmds[0] = '{2'd3, 8'h00, 4'd2};
        cmds[1] = '{2'd2, 8'h00, 4'd3};
        cmds[2] = '{2'd1, 8'h5A, 4'd7};
        cmds[3] = '{2'd3, 8'h00, 4'd0};
        cmds[4] = '{2'd0, 8'h99, 4'd3};
        cmds[5] = '{2'd2, 8'h00, 4'd1};
        cmds[6] = '{2'd1, 8'hFF, 4'd0};
        cmds[7] = '{2'd3, 8'h00, 4'd3};

        drive(1'b0, 2'd0, 8'h00, 4'd0, 1'b0);
        Reset = 1'b1;
        repeat (2) @(posedge Clock);

        for (int v = 0; v < NV; v++) begin
            @(negedge Clock);
            Reset = vt[v].rst;
            drive(vt[v].valid, vt[v].op, vt[v].data, vt[v].cnt, vt[v].hold);
            #1;
            chk($sformatf("vec%0d E", v),         32'(bus.E),         32'(vt[v].e));
            chk($sformatf("vec%0d FunSel", v),    32'(bus.FunSel),    32'(vt[v].fs));
            chk($sformatf("vec%0d I", v),         32'(bus.I),         32'(vt[v].i));
            chk($sformatf("vec%0d Shadow", v),    32'(bus.Shadow),    32'(vt[v].sh));
            chk($sformatf("vec%0d cmd_ready", v), 32'(bus.cmd_ready), 32'(vt[v].rdy));
            chk($sformatf("vec%0d busy", v),      32'(bus.busy),      32'(vt[v].busy));
            chk($sformatf("vec%0d done", v),      32'(bus.done),      32'(vt[v].done));
        end

        // inc x15 from 00, reset lands after the fifth issue
        @(negedge Clock);
        drive(1'b1, FS_INC, 8'h00, 4'd15, 1'b0);
        #1;
        chk("rst_seq accept ready", 32'(bus.cmd_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            drive(1'b0, 2'd0, 8'h00, 4'd0, 1'b0);
            #1;
            chk($sformatf("rst_seq issue%0d E", k), 32'(bus.E), 32'd1);
            chk($sformatf("rst_seq issue%0d Shadow", k), 32'(bus.Shadow), 32'(k));
        end
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        chk("rst_seq pre Shadow", 32'(bus.Shadow), 32'h05);
        chk("rst_seq E during reset", 32'(bus.E), 32'd0);
        chk("rst_seq ready during reset", 32'(bus.cmd_ready), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("rst_seq post Shadow", 32'(bus.Shadow), 32'h00);
        chk("rst_seq post E", 32'(bus.E), 32'd0);
        chk("rst_seq post ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_seq post busy", 32'(bus.busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            #1;
            chk($sformatf("rst_seq no done %0d", k), 32'(bus.done), 32'd0);
        end

        // cmd_valid held high across back-to-back commands with random hold
        begin
            int         ci;
            int         done_cnt;
            int         e_cnt;
            int         pend_k;
            int         cycles;
            logic [7:0] model_sh;
            logic [7:0] pend_exp;
            logic       cur_valid;
            ci       = 0;
            done_cnt = 0;
            e_cnt    = 0;
            pend_k   = 0;
            cycles   = 0;
            model_sh = 8'h00;
            pend_exp = 8'h00;
            while (done_cnt < NC && cycles < 400) begin
                @(negedge Clock);
                cycles++;
                cur_valid = (ci < NC);
                if (cur_valid)
                    drive(1'b1, cmds[ci].op, cmds[ci].data, cmds[ci].cnt, $urandom_range(0, 3) == 0);
                else
                    drive(1'b0, 2'd0, 8'h00, 4'd0, $urandom_range(0, 3) == 0);
                #1;
                if (bus.done) begin
                    chk($sformatf("sb cmd%0d Shadow", done_cnt), 32'(bus.Shadow), 32'(pend_exp));
                    chk($sformatf("sb cmd%0d issues", done_cnt), 32'(e_cnt), 32'(pend_k));
                    done_cnt++;
                end
                if (bus.E) e_cnt++;
                if (cur_valid && bus.cmd_ready) begin
                    pend_k = cmds[ci].op[1] ? ((cmds[ci].cnt == 4'd0) ? 1 : int'(cmds[ci].cnt)) : 1;
                    pend_exp = model_sh;
                    for (int r = 0; r < pend_k; r++)
                        pend_exp = next_shadow(cmds[ci].op, pend_exp, cmds[ci].data);
                    model_sh = pend_exp;
                    e_cnt = 0;
                    ci++;
                end
            end
            chk("sb commands completed", 32'(done_cnt), 32'(NC));
            chk("sb commands accepted", 32'(ci), 32'(NC));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
